// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit.
// Ports: clk, reset (async low), start/op/a/b in; busy/done/div_zero/hi/lo out.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FINISH,
    S_DZERO
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] wlo_q, wlo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic             asign_q, asign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mext, bsum;
  logic [2*WIDTH+1:0] mcat, msh;
  logic [WIDTH:0]     rsh, trial, rnext;
  logic               qbit;
  logic [WIDTH-1:0]   qnext, quot_f, rem_f;
  logic               last;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign last  = (cnt_q == CW'(WIDTH - 1));

  // Booth step: acc is one bit wider so +/- of the most
  // negative multiplicand cannot overflow before the shift.
  always_comb begin
    mext = {mcand_q[WIDTH-1], mcand_q};
    unique case ({wlo_q[0], qm1_q})
      2'b01:   bsum = acc_q + mext;
      2'b10:   bsum = acc_q - mext;
      default: bsum = acc_q;
    endcase
    mcat = {bsum, wlo_q, qm1_q};
    msh  = {mcat[2*WIDTH+1], mcat[2*WIDTH+1:1]};
  end

  // Restoring step: dividend magnitude shifts out of wlo
  // while quotient bits shift in behind it.
  always_comb begin
    rsh    = {acc_q[WIDTH-1:0], wlo_q[WIDTH-1]};
    trial  = rsh - {1'b0, mcand_q};
    qbit   = ~trial[WIDTH];
    rnext  = qbit ? trial : rsh;
    qnext  = {wlo_q[WIDTH-2:0], qbit};
    quot_f = neg_q ? -qnext : qnext;
    rem_f  = asign_q ? -rnext[WIDTH-1:0] : rnext[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wlo_d   = wlo_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    asign_d = asign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          if (!op) begin
            mcand_d = a;
            wlo_d   = b;
            state_d = S_MULT;
          end else if (b == '0) begin
            state_d = S_DZERO;
          end else begin
            mcand_d = b_mag;
            wlo_d   = a_mag;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            asign_d = a[WIDTH-1];
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        acc_d = msh[2*WIDTH+1:WIDTH+1];
        wlo_d = msh[WIDTH:1];
        qm1_d = msh[0];
        cnt_d = cnt_q + CW'(1);
        // Results land on the final iteration edge so they
        // are already visible while done is high.
        if (last) begin
          hi_d    = msh[2*WIDTH:WIDTH+1];
          lo_d    = msh[WIDTH:1];
          state_d = S_FINISH;
        end
      end
      S_DIV: begin
        acc_d = rnext;
        wlo_d = qnext;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          hi_d    = rem_f;
          lo_d    = quot_f;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_DZERO:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      wlo_q   <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      asign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wlo_q   <= wlo_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      asign_q <= asign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == S_MULT) || (state_q == S_DIV) ||
                    (state_q == S_FINISH);
  assign done     = (state_q == S_FINISH) || (state_q == S_DZERO);
  assign div_zero = (state_q == S_DZERO);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
